serial_add8: RTL and testbench

Bit-serial two's-complement adder that computes S = A + B + cin one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the additive counterpart of the 8-bit ripple-borrow subtractor: same operand width and same flag semantics (carry instead of borrow), trading combinational depth for WIDTH cycles of latency. A start/busy/done handshake lets a controller issue back-to-back operations.

---
 rtl/serial_add8_if.sv | 50 +++++
 rtl/serial_add8.sv | 146 ++++++++++++++
 tb/tb_serial_add8.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add8_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add8_if
//  Description : Operation handshake and operand/result bundle for the
//                bit-serial adder. The controller drives start/operands,
//                the adder returns status and the registered result.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_add8_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    // Controller side: issues operations, observes status and result
    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  s,
        input  cout,
        input  ovf
    );

    // Adder side: accepts operations, reports status and result
    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output s,
        output cout,
        output ovf
    );

endinterface : serial_add8_if
`default_nettype wire

// File: rtl/serial_add8.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add8
//  Description : Bit-serial two's-complement adder. Computes
//                S = A + B + cin one bit per clock, LSB first, using one
//                full-adder cell and a carry flop. Result, carry-out and
//                signed overflow are registered and held between operations.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add8 #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_add8_if.slave   bus
);

    // Bit counter only needs to reach WIDTH-1; it is reloaded on every start.
    localparam int                 c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Operand shift registers, carry flop and bit counter
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rs;
    logic               r_c;
    logic [c_cnt_w-1:0] r_n;

    // Registered, held result
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    // Control strobes and full-adder cell
    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_sum_bit;
    logic               w_carry;
    logic [WIDTH-1:0]   w_rs_next;

    // Single full-adder cell working on the current LSBs and the carry flop
    always_comb begin
        w_sum_bit = r_a[0] ^ r_b[0] ^ r_c;
        w_carry   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
        w_rs_next = {w_sum_bit, r_rs[WIDTH-1:1]};
        w_last    = (r_n == c_last);
    end

    // Next-state and control decode; start is only honoured in IDLE or DONE
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture and one-bit-per-clock shift datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_rs <= '0;
            r_c  <= 1'b0;
            r_n  <= '0;
        end else if (w_accept) begin
            r_a  <= bus.a;
            r_b  <= bus.b;
            r_rs <= '0;
            r_c  <= bus.cin;
            r_n  <= '0;
        end else if (w_shift) begin
            r_a  <= r_a >> 1;
            r_b  <= r_b >> 1;
            r_rs <= w_rs_next;
            r_c  <= w_carry;
            r_n  <= r_n + c_one;
        end
    end

    // Result registers load only on the final bit, so they hold through RUN;
    // overflow is carry-into-MSB (the flop before update) xor carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_shift && w_last) begin
            r_sum  <= w_rs_next;
            r_cout <= w_carry;
            r_ovf  <= r_c ^ w_carry;
        end
    end

    // Status is decoded from the state register only
    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.s    = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule : serial_add8
`default_nettype wire

// File: tb/tb_serial_add8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add8
//  Description : Self-checking bench for serial_add8 with a result
//                scoreboard, directed carry/overflow/reset cases and
//                randomized back-to-back traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add8;

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    exp_t sb[$];

    serial_add8_if #(.WIDTH(8)) bus ();

    serial_add8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t       e;
        logic [8:0] full;
        full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        e.s    = full[7:0];
        e.cout = full[8];
        e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        return e;
    endfunction

    // Result monitor: every done pulse pops one expected entry
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_busy_overlap", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_s",    {24'd0, bus.s},    {24'd0, e.s});
                check("sb_cout", {31'd0, bus.cout}, {31'd0, e.cout});
                check("sb_ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
            end
        end
    end

    // Issue one operation from a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input exp_t e);
        int edges;
        int busy_cnt;
        int seen;
        edges    = 0;
        busy_cnt = 0;
        seen     = 0;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
            bus.cin   = 1'($urandom);
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            edges++;
        end
        check("done_seen", seen, 1);
        check("latency", edges, 8);
        check("busy_cycles", busy_cnt, 8);
    endtask

    task automatic wait_done(output int at);
        int seen;
        seen = 0;
        at   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                at   = cyc;
                break;
            end
        end
        check("wait_done", seen, 1);
    endtask

    initial begin
        int   t1, t2, dones;
        exp_t e;
        logic [7:0] ra, rb;
        logic       rc;

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_s",    {24'd0, bus.s},    0);
        check("rst_cout", {31'd0, bus.cout}, 0);
        check("rst_ovf",  {31'd0, bus.ovf},  0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values with hand-computed results
        run_op(8'd0,   8'd0,   1'b0, '{s: 8'd0,   cout: 1'b0, ovf: 1'b0});
        run_op(8'd1,   8'd1,   1'b0, '{s: 8'd2,   cout: 1'b0, ovf: 1'b0});
        run_op(8'd8,   8'd5,   1'b0, '{s: 8'd13,  cout: 1'b0, ovf: 1'b0});
        run_op(8'd36,  8'd12,  1'b0, '{s: 8'd48,  cout: 1'b0, ovf: 1'b0});
        run_op(8'd200, 8'd128, 1'b0, '{s: 8'd72,  cout: 1'b1, ovf: 1'b1});
        run_op(8'd255, 8'd199, 1'b0, '{s: 8'd198, cout: 1'b1, ovf: 1'b0});
        run_op(8'd100, 8'd100, 1'b0, '{s: 8'd200, cout: 1'b0, ovf: 1'b1});
        run_op(8'd255, 8'd0,   1'b1, '{s: 8'd0,   cout: 1'b1, ovf: 1'b0});
        repeat (2) @(negedge clk);

        // start held high: back-to-back, operands changed mid-RUN
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd4;
        bus.cin   = 1'b0;
        sb.push_back('{s: 8'd7, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'd20;
        bus.b = 8'd21;
        sb.push_back('{s: 8'd41, cout: 1'b0, ovf: 1'b0});
        wait_done(t1);
        @(posedge clk);
        @(negedge clk);
        bus.a     = 8'hee;
        bus.b     = 8'h11;
        bus.cin   = 1'b1;
        bus.start = 1'b0;
        wait_done(t2);
        check("b2b_gap", t2 - t1, 9);
        repeat (2) @(negedge clk);

        // Reset on the 4th RUN cycle of 200+128 discards the operation
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd128;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 0);
        check("midrst_done", {31'd0, bus.done}, 0);
        check("midrst_s",    {24'd0, bus.s},    0);
        check("midrst_cout", {31'd0, bus.cout}, 0);
        check("midrst_ovf",  {31'd0, bus.ovf},  0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(8'd8, 8'd5, 1'b0, '{s: 8'd13, cout: 1'b0, ovf: 1'b0});

        // Random traffic with random idle gaps (gap 0 exercises DONE+start)
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            e  = model(ra, rb, rc);
            run_op(ra, rb, rc, e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #5ms;
        $display("FAIL timeout got=%0d expected=finish", cyc);
        $fatal(1, "time limit reached");
    end

endmodule : tb_serial_add8
`default_nettype wire
